// File: rtl/serial_nbit_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry FF, LSB first, start/busy/done handshake.
// Optional subtract mode and signed-overflow flag when SERIAL_ADDER_SUBTRACT_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for start; sum/cout hold the last result
//   RUN    | WIDTH cycles, one result bit per edge
//   DONE   | one-cycle done pulse; sum/cout final
module serial_nbit_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub_i,
  output logic             overflow_o,
`endif
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, sum_q;
  logic [CW-1:0]    count_q;
  logic             carry_q, cout_q, busy_q, done_q;

  logic             fa_b, fa_s, fa_c, carry_init;
  logic [WIDTH-1:0] msb_bit, sum_d;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  logic sub_q, ovf_q;
  assign fa_b       = op_b_q[0] ^ sub_q;
  assign carry_init = sub_i;
  assign overflow_o = ovf_q;
`else
  assign fa_b       = op_b_q[0];
  assign carry_init = 1'b0;
`endif

  assign fa_s = op_a_q[0] ^ fa_b ^ carry_q;
  assign fa_c = (op_a_q[0] & fa_b) | (op_a_q[0] & carry_q) | (fa_b & carry_q);

  // New bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB result.
  always_comb begin
    msb_bit            = '0;
    msb_bit[WIDTH-1]   = fa_s;
    sum_d              = (sum_q >> 1) | msb_bit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_a_q  <= a_i;
            op_b_q  <= b_i;
            carry_q <= carry_init;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef SERIAL_ADDER_SUBTRACT_EN
            sub_q   <= sub_i;
`endif
          end
        end
        S_RUN: begin
          sum_q   <= sum_d;
          op_a_q  <= op_a_q >> 1;
          op_b_q  <= op_b_q >> 1;
          carry_q <= fa_c;
          if (count_q == LAST) begin
            cout_q  <= fa_c;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef SERIAL_ADDER_SUBTRACT_EN
            ovf_q   <= carry_q ^ fa_c;
`endif
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_serial_nbit_adder.sv
// Directed bench for serial_nbit_adder: WIDTH=8 instance for handshake/timing, WIDTH=4 instance exhaustive.
module tb_serial_nbit_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, sum8;
  logic [3:0] a4, b4, sum4;
  logic       cout8, busy8, done8, cout4, busy4, done4;
`ifdef SERIAL_ADDER_SUBTRACT_EN
  logic       sub8, ovf8, sub4, ovf4;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [9:0] sb8[$];   // {ovf, cout, sum}
  logic [4:0] sb4[$];   // {cout, sum}

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_nbit_adder #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub_i(sub8), .overflow_o(ovf8),
`endif
    .sum_o(sum8), .cout_o(cout8), .busy_o(busy8), .done_o(done8)
  );

  serial_nbit_adder #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub_i(sub4), .overflow_o(ovf4),
`endif
    .sum_o(sum4), .cout_o(cout4), .busy_o(busy4), .done_o(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer add on the (optionally inverted) operand.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] bb;
    logic [8:0] r;
    logic       ovf;
    bb  = s ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {8'd0, s};
    ovf = (a[7] == bb[7]) && (r[7] != a[7]);
    return {ovf, r};
  endfunction

  task automatic check_result8(input string tag);
    logic [9:0] e;
    e = sb8.pop_front();
    chk({tag, "_sum"}, 32'(sum8), 32'(e[7:0]));
    chk({tag, "_cout"}, 32'(cout8), 32'(e[8]));
`ifdef SERIAL_ADDER_SUBTRACT_EN
    chk({tag, "_ovf"}, 32'(ovf8), 32'(e[9]));
`endif
  endtask

  // Called just after the accepting edge; returns edges until done is visible and busy cycles seen.
  task automatic wait_done8(output int edges, output int bcnt);
    logic got;
    edges = 0; bcnt = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy8) bcnt++;
      if (done8) begin got = 1'b1; break; end
      @(posedge clk);
      edges++;
    end
    if (!got) chk("done8_timeout", 32'(done8), 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    int edges, bcnt;
    @(posedge clk); #1;
    a8 = a; b8 = b; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    sub8 = s;
`endif
    sb8.push_back(model8(a, b, s));
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    wait_done8(edges, bcnt);
    chk({tag, "_latency"}, 32'(edges), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd9);
    check_result8(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
    chk({tag, "_busy_clear"}, 32'(busy8), 32'd0);
  endtask

  initial begin
    int dcnt, edges, bcnt, last_done;
    logic got;
    logic [4:0] e4;

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    sub8 = 1'b0; sub4 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);

    run_op(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(8'h00, 8'h00, 1'b0, "add_00_00");

    // Second start while busy must be ignored.
    @(posedge clk); #1;
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    sb8.push_back(model8(8'h12, 8'h34, 1'b0));
    @(posedge clk); #1 start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin
        dcnt++;
        if (dcnt == 1) check_result8("ignore_start");
      end
    end
    chk("ignore_start_done_count", 32'(dcnt), 32'd1);
    chk("ignore_start_idle", 32'(busy8), 32'd0);

    // Reset in the middle of RUN discards the operation.
    @(posedge clk); #1;
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_sum", 32'(sum8), 32'd0);
    chk("midrst_cout", 32'(cout8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
`ifdef SERIAL_ADDER_SUBTRACT_EN
    chk("midrst_ovf", 32'(ovf8), 32'd0);
`endif
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    run_op(8'h01, 8'h02, 1'b0, "after_rst");

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    repeat (3) sb8.push_back(model8(8'h80, 8'h80, 1'b0));
    last_done = -1;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done8) begin got = 1'b1; break; end
      end
      if (!got) chk("stream_timeout", 32'(done8), 32'd1);
      if (k == 2) start8 = 1'b0;
      check_result8("stream");
      if (last_done >= 0) chk("stream_period", 32'(cyc - last_done), 32'd10);
      last_done = cyc;
    end
    repeat (2) @(negedge clk);
    chk("stream_stop", 32'(busy8), 32'd0);

`ifdef SERIAL_ADDER_SUBTRACT_EN
    run_op(8'h10, 8'h20, 1'b1, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, "sub_80_01");
    run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
`endif

    // Exhaustive WIDTH=4 against integer addition.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = i[7:0];
      @(posedge clk); #1;
      a4 = v[7:4]; b4 = v[3:0]; start4 = 1'b1;
      sb4.push_back({1'b0, v[7:4]} + {1'b0, v[3:0]});
      @(posedge clk); #1 start4 = 1'b0;
      got = 1'b0;
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        if (done4) begin got = 1'b1; break; end
      end
      if (!got) chk("w4_timeout", 32'(done4), 32'd1);
      e4 = sb4.pop_front();
      chk("w4_result", 32'({cout4, sum4}), 32'(e4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
